// File: rtl/run_pkg.sv
// Shared definitions for the run-length detector: FSM encoding and the
// saturating increment used by the run counter.
package run_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] COUNT = 2'b01;
    localparam logic [1:0] HIT   = 2'b10;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned cnt_w);
        logic [31:0] max_v;
        max_v = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
        return (cnt >= max_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (priority over increment)
// and asynchronous active-high reset.
module sat_counter
    import run_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = W'(sat_inc(32'(q_q), W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/run_length_detector.sv
// Serial run detector: counts consecutive matching qualified samples, flags
// runs of at least MIN_RUN bits and reports each qualifying run's length when it ends.
module run_length_detector
    import run_pkg::*;
#(
    parameter int unsigned MIN_RUN  = 2,
    parameter int unsigned CNT_W    = 4,
    parameter bit          MEALY    = 1'b0,
    parameter bit          POLARITY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] run_len,
    output logic             run_done,
    output logic [CNT_W-1:0] done_len
);

    logic [1:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] done_len_q, done_len_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_inc;
    logic             match, brk;

    assign match = en & (in == POLARITY);
    assign brk   = en & (in != POLARITY);

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .q_o   (cnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        done_d     = 1'b0;
        done_len_d = done_len_q;
        case (state_q)
            IDLE: begin
                if (match) begin
                    cnt_inc = 1'b1;
                    state_d = (MIN_RUN == 1) ? HIT : COUNT;
                end
            end
            COUNT: begin
                if (match) begin
                    cnt_inc = 1'b1;
                    if (32'(cnt) + 32'd1 == MIN_RUN) begin
                        state_d = HIT;
                    end
                end else if (brk) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            HIT: begin
                if (match) begin
                    cnt_inc = 1'b1;
                end else if (brk) begin
                    cnt_clr    = 1'b1;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    done_len_d = cnt;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            done_len_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            done_len_q <= done_len_d;
        end
    end

    generate
        if (MEALY) begin : g_mealy
            // cnt >= MIN_RUN-1 written without the subtraction; reset forces low.
            assign out = match & ~reset & (32'(cnt) + 32'd1 >= MIN_RUN);
        end else begin : g_moore
            assign out = (state_q == HIT);
        end
    endgenerate

    assign run_len  = cnt;
    assign run_done = done_q;
    assign done_len = done_len_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench: three detector configurations share one stimulus stream and
// are checked every cycle against a run-length reference model.
module tb_run_length_detector;

    localparam int MINR [3] = '{2, 3, 1};
    localparam int CW   [3] = '{4, 4, 3};
    localparam int MEA  [3] = '{0, 1, 0};
    localparam int POL  [3] = '{1, 1, 0};

    typedef struct packed {
        logic [2:0]      out;
        logic [2:0]      rd;
        logic [2:0][3:0] rl;
        logic [2:0][3:0] dl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic in = 1'b0;

    logic       out0, out1, out2, rd0, rd1, rd2;
    logic [3:0] rl0, rl1, dl0, dl1;
    logic [2:0] rl2, dl2;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   run    [3];
    logic done_p [3];
    int   done_l [3];

    always #5 clk = ~clk;

    run_length_detector #(.MIN_RUN(2), .CNT_W(4), .MEALY(1'b0), .POLARITY(1'b1)) u_d0 (
        .clk(clk), .reset(reset), .en(en), .in(in),
        .out(out0), .run_len(rl0), .run_done(rd0), .done_len(dl0)
    );

    run_length_detector #(.MIN_RUN(3), .CNT_W(4), .MEALY(1'b1), .POLARITY(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .in(in),
        .out(out1), .run_len(rl1), .run_done(rd1), .done_len(dl1)
    );

    run_length_detector #(.MIN_RUN(1), .CNT_W(3), .MEALY(1'b0), .POLARITY(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .en(en), .in(in),
        .out(out2), .run_len(rl2), .run_done(rd2), .done_len(dl2)
    );

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input int d, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUTs must show half a cycle later.
    task automatic step(input logic r, input logic e, input logic b);
        exp_t x;
        logic m, k;
        int   mx;
        @(posedge clk);
        #1;
        reset = r;
        en    = e;
        in    = b;
        for (int d = 0; d < 3; d++) begin
            mx = (1 << CW[d]) - 1;
            if (r) begin
                run[d]    = 0;
                done_p[d] = 1'b0;
                done_l[d] = 0;
            end
            m = e && (int'(b) == POL[d]);
            k = e && (int'(b) != POL[d]);
            if (MEA[d] != 0) x.out[d] = !r && m && (run[d] + 1 >= MINR[d]);
            else             x.out[d] = (run[d] >= MINR[d]);
            x.rl[d] = 4'(imin(run[d], mx));
            x.rd[d] = done_p[d];
            x.dl[d] = 4'(done_l[d]);
            if (!r) begin
                done_p[d] = 1'b0;
                if (m) begin
                    run[d] = imin(run[d] + 1, 1000);
                end else if (k) begin
                    if (run[d] >= MINR[d]) begin
                        done_p[d] = 1'b1;
                        done_l[d] = imin(run[d], mx);
                    end
                    run[d] = 0;
                end
            end
        end
        sb_q.push_back(x);
    endtask

    task automatic seq(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i] == 8'h31);
    endtask

    task automatic rep(input logic b, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, b);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: compare every observed cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        logic [2:0]      ao, ar;
        logic [2:0][3:0] al, ad;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                ao = {out2, out1, out0};
                ar = {rd2, rd1, rd0};
                al = {{1'b0, rl2}, rl1, rl0};
                ad = {{1'b0, dl2}, dl1, dl0};
                for (int d = 0; d < 3; d++) begin
                    chk("out",      d, {3'b0, ao[d]}, {3'b0, e.out[d]});
                    chk("run_done", d, {3'b0, ar[d]}, {3'b0, e.rd[d]});
                    chk("run_len",  d, al[d], e.rl[d]);
                    chk("done_len", d, ad[d], e.dl[d]);
                end
            end
        end
    end

    initial begin
        logic cur;
        for (int d = 0; d < 3; d++) begin
            run[d]    = 0;
            done_p[d] = 1'b0;
            done_l[d] = 0;
        end
        do_reset();
        seq("011100");
        seq("00");
        do_reset();
        seq("11011110");
        seq("0");
        do_reset();
        rep(1'b1, 12);
        seq("00");
        rep(1'b1, 20);
        seq("00");
        rep(1'b0, 12);
        seq("11");
        // Qualifier gaps: held samples must not break or extend the run.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        seq("100");
        do_reset();
        seq("101");
        seq("11");
        // Reset in the middle of a qualifying run discards it.
        rep(1'b1, 5);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        seq("1110");
        rep(1'b0, 6);
        seq("1");
        cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 25) cur = ~cur;
            if ($urandom_range(0, 399) == 0) step(1'b1, 1'b1, cur);
            else step(1'b0, $urandom_range(0, 99) < 80, cur);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
